k_dragonfly_sequencer: RTL and testbench
========================================

Name: k_dragonfly_sequencer

Overview:
- Sequential controller that runs a complete in-place radix-4 DIT FFT over a single-port sample RAM. Input data is stored in digit-reversed order.
- For each butterfly it reads the four operands and fetches the twiddle from a ROM. It then presents both to the floating-point dragonfly, captures the four results and writes them back to the same addresses.
- It is the producer/consumer for the dragonfly datapath. Samples are 64-bit complex: {re[63:32], im[31:0]}, IEEE-754 single.

Parameters:
- LOG4N, 4: number of radix-4 stages. N = 4^LOG4N points.
- AW, 2*LOG4N: sample RAM and twiddle ROM address width.
- DF_WAIT, 1: cycles (>=1) allowed for the dragonfly to settle before its outputs are captured.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin an FFT; sampled only in IDLE.
- scaling  in  2  per-stage scaling code, forwarded unchanged to the dragonfly.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.
- mem_addr  out  AW  sample RAM address.
- mem_we  out  1  sample RAM write enable.
- mem_wdata  out  64  sample RAM write data.
- mem_rdata  in  64  sample RAM read data; synchronous, 1-cycle latency.
- tw_addr  out  AW  twiddle ROM address (exponent e of W_N^e).
- tw_data  in  64  twiddle ROM data; 1-cycle latency.
- df_in0..df_in3  out  64 each  dragonfly operands (registered).
- df_twiddle  out  64  dragonfly twiddle (registered).
- df_scaling  out  2  dragonfly scaling code.
- df_out0..df_out3  in  64 each  dragonfly results (combinational from df_in*).

Behaviour:
- Reset, async on rst_n low:
  - FSM returns to IDLE; stage and butterfly counters clear.
  - busy, done, mem_we, mem_addr, mem_wdata, tw_addr, df_in*, df_twiddle and df_scaling all go to 0.
  - Reset mid-operation abandons the FFT; RAM contents are undefined.
- Addressing for stage s (0..LOG4N-1) and butterfly b (0..N/4-1):
  - L = 4^s, j = b mod L, g = b / L, base = g*4L + j.
  - Operand k sits at base + k*L.
  - Twiddle exponent e = j * 4^(LOG4N-1-s).
  - All arithmetic is unsigned AW-bit; it never overflows for legal counters.
- Operand mapping: df_in0 = x[base], df_in1 = x[base+2L], df_in2 = x[base+L], df_in3 = x[base+3L]. df_outk is written back to base + k*L.
- FSM states: IDLE -> RD -> RDW -> CALC -> WR, then next butterfly or DONE.
  - IDLE: on start=1, latch scaling into df_scaling and go to RD. busy rises on the next edge.
  - RD (4 cycles, cnt 0..3):
    - mem_addr = address of operand cnt, mem_we = 0.
    - On cnt 0, tw_addr = e.
    - Data for operand cnt-1 is captured each cycle; tw_data is captured on cnt 1.
  - RDW (1 cycle): capture operand 3. df_in* and df_twiddle are then stable.
  - CALC (DF_WAIT cycles): on the last cycle, register df_out0..3 into write buffers.
  - WR (4 cycles, cnt 0..3): mem_we = 1, mem_addr = base + cnt*L, mem_wdata = buffer[cnt].
  - After WR: advance b. At b = N/4-1, set b = 0 and advance s. After the last butterfly of stage LOG4N-1, go to DONE.
  - DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Per-butterfly cost is 9 + DF_WAIT cycles. Total from the start cycle to the done pulse is 1 + LOG4N*(N/4)*(9+DF_WAIT) cycles.
- mem_we is 0 in every state except WR. Writes of a butterfly never overlap its own reads.
- start while busy is ignored. start in the DONE cycle is ignored.
- df_scaling stays constant for the whole run.

Test Plan:
1. Reset mid-run: assert rst_n=0 during WR of butterfly 2 -> next cycle busy=0, mem_we=0, all outputs 0. A following start runs a full FFT correctly.
2. Address trace with LOG4N=2, DF_WAIT=1, start once:
   - Stage 0 read groups {0,1,2,3} ... {12..15}, all tw_addr 0.
   - Stage 1 groups {0,4,8,12}, {1,5,9,13}, {2,6,10,14}, {3,7,11,15} with tw_addr 0, 1, 2, 3.
   - done pulses exactly 81 cycles after the start cycle.
3. Impulse: RAM = x[0]=1.0+0j, others 0, scaling=0, real dragonfly attached -> every bin reads back 0x3F800000_00000000.
4. DC: all 16 samples 1.0, scaling=2'b01 -> bin 0 = 4.0 (0x40800000_00000000), bins 1..15 = 0.
5. start pulsed again while busy, and again in the DONE cycle -> ignored; exactly one done pulse, cycle count unchanged.
6. Operand routing: stub dragonfly with df_outk = df_in(k) -> after one butterfly, base+L holds the old base+2L value and base+2L holds the old base+L value. Verify with the pattern x[i]=i.

Source files
------------

// File: rtl/k_dragonfly_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : k_dragonfly_sequencer
//  Purpose  : Sequences a complete in-place radix-4 DIT FFT over a single-port
//             sample RAM (input stored digit-reversed). For each butterfly it
//             reads four operands plus a twiddle, presents them to an external
//             floating-point dragonfly, captures the four results and writes
//             them back to the same addresses.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             start, scaling      - run request (IDLE only), scaling code
//             busy, done          - run in progress / one-cycle completion
//             mem_addr/we/wdata   - sample RAM port (1-cycle read latency)
//             mem_rdata           - sample RAM read data
//             tw_addr, tw_data    - twiddle ROM exponent / data (1-cycle)
//             df_in0..3, df_twiddle, df_scaling - registered dragonfly inputs
//             df_out0..3          - dragonfly results (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module k_dragonfly_sequencer #(
    parameter int LOG4N   = 4,
    parameter int AW      = 2 * LOG4N,
    parameter int DF_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    scaling,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [63:0]   mem_wdata,
    input  logic [63:0]   mem_rdata,
    output logic [AW-1:0] tw_addr,
    input  logic [63:0]   tw_data,
    output logic [63:0]   df_in0,
    output logic [63:0]   df_in1,
    output logic [63:0]   df_in2,
    output logic [63:0]   df_in3,
    output logic [63:0]   df_twiddle,
    output logic [1:0]    df_scaling,
    input  logic [63:0]   df_out0,
    input  logic [63:0]   df_out1,
    input  logic [63:0]   df_out2,
    input  logic [63:0]   df_out3
);

    localparam int c_sw = (LOG4N > 1) ? $clog2(LOG4N) : 1;
    localparam int c_ww = (DF_WAIT > 1) ? $clog2(DF_WAIT) : 1;
    localparam logic [c_sw-1:0] c_last_stage = c_sw'(LOG4N - 1);
    localparam logic [AW-1:0]   c_last_bfly  = AW'((1 << (AW - 2)) - 1);
    localparam logic [c_ww-1:0] c_last_wait  = c_ww'(DF_WAIT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RDW  = 3'd2,
        S_CALC = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [c_sw-1:0] r_stage;
    logic [AW-1:0]   r_bfly;
    logic [1:0]      r_cnt;
    logic [c_ww-1:0] r_wait;
    logic [63:0]     r_buf [4];

    // Butterfly addressing: L = 4^s, j = b mod L, g = b / L,
    // base = g*4L + j, operand k at base + k*L, twiddle e = j * 4^(LOG4N-1-s).
    // Powers of four become shifts by 2*s.
    logic [c_sw:0]   w_lsh;
    logic [c_sw:0]   w_esh;
    logic [AW-1:0]   w_l;
    logic [AW-1:0]   w_j;
    logic [AW-1:0]   w_g;
    logic [AW-1:0]   w_base;
    logic [AW-1:0]   w_op_addr;
    logic [AW-1:0]   w_exp;

    always_comb begin
        w_lsh     = {r_stage, 1'b0};
        w_esh     = {c_last_stage - r_stage, 1'b0};
        w_l       = AW'(1) << w_lsh;
        w_j       = r_bfly & (w_l - AW'(1));
        w_g       = r_bfly >> w_lsh;
        w_base    = ((w_g << w_lsh) << 2) | w_j;
        w_op_addr = w_base + (w_l * AW'(r_cnt));
        w_exp     = w_j << w_esh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and RAM/ROM-facing outputs; everything idles at zero so the
    // outputs read 0 whenever the FSM sits in IDLE (including under reset).
    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tw_addr   = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                busy     = 1'b1;
                mem_addr = w_op_addr;
                if (r_cnt == 2'd0) begin
                    tw_addr = w_exp;
                end
                if (r_cnt == 2'd3) begin
                    w_next = S_RDW;
                end
            end
            S_RDW: begin
                busy   = 1'b1;
                w_next = S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                if (r_wait == c_last_wait) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = w_op_addr;
                mem_wdata = r_buf[r_cnt];
                if (r_cnt == 2'd3) begin
                    if ((r_bfly == c_last_bfly) && (r_stage == c_last_stage)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Counters and datapath capture. RAM data for the address issued in one
    // cycle is available in the next, so operand k lands one cycle after it
    // was addressed; operands 1 and 2 are crossed onto df_in2 / df_in1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_bfly     <= '0;
            r_cnt      <= '0;
            r_wait     <= '0;
            df_in0     <= '0;
            df_in1     <= '0;
            df_in2     <= '0;
            df_in3     <= '0;
            df_twiddle <= '0;
            df_scaling <= '0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        df_scaling <= scaling;
                        r_stage    <= '0;
                        r_bfly     <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 2'd1;
                    case (r_cnt)
                        2'd1: begin
                            df_in0     <= mem_rdata;
                            df_twiddle <= tw_data;
                        end
                        2'd2:    df_in2 <= mem_rdata;
                        2'd3:    df_in1 <= mem_rdata;
                        default: ;
                    endcase
                end
                S_RDW: begin
                    df_in3 <= mem_rdata;
                    r_wait <= '0;
                end
                S_CALC: begin
                    r_wait <= r_wait + c_ww'(1);
                    if (r_wait == c_last_wait) begin
                        r_buf[0] <= df_out0;
                        r_buf[1] <= df_out1;
                        r_buf[2] <= df_out2;
                        r_buf[3] <= df_out3;
                    end
                end
                S_WR: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        if (r_bfly == c_last_bfly) begin
                            r_bfly <= '0;
                            if (r_stage == c_last_stage) begin
                                r_stage <= '0;
                            end else begin
                                r_stage <= r_stage + c_sw'(1);
                            end
                        end else begin
                            r_bfly <= r_bfly + AW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_k_dragonfly_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_k_dragonfly_sequencer
//  Purpose  : Scoreboard bench for k_dragonfly_sequencer (LOG4N=2, N=16).
//             A RAM model, twiddle ROM and integer stub dragonfly surround the
//             DUT; a loop-level FFT schedule predicts every write-back.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_k_dragonfly_sequencer;

    localparam int LOG4N   = 2;
    localparam int AW      = 2 * LOG4N;
    localparam int DF_WAIT = 1;
    localparam int N       = 4 ** LOG4N;
    localparam int NB      = N / 4;
    localparam int EXP_LAT = 1 + LOG4N * NB * (9 + DF_WAIT);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    scaling = 2'b00;
    logic          busy, done, mem_we;
    logic [AW-1:0] mem_addr, tw_addr;
    logic [63:0]   mem_wdata, mem_rdata, tw_data;
    logic [63:0]   df_in0, df_in1, df_in2, df_in3, df_twiddle;
    logic [1:0]    df_scaling;
    logic [63:0]   df_out0, df_out1, df_out2, df_out3;

    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [63:0]   ld_data = '0;
    logic [63:0]   ram [N];
    logic [63:0]   model [N];

    typedef struct {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;
    wr_t exp_q[$];
    wr_t mon_w;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wr_seen = 0;
    int done_seen = 0;
    int done_cyc = 0;

    k_dragonfly_sequencer #(.LOG4N(LOG4N), .AW(AW), .DF_WAIT(DF_WAIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .scaling(scaling),
        .busy(busy), .done(done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .tw_addr(tw_addr), .tw_data(tw_data),
        .df_in0(df_in0), .df_in1(df_in1), .df_in2(df_in2), .df_in3(df_in3),
        .df_twiddle(df_twiddle), .df_scaling(df_scaling),
        .df_out0(df_out0), .df_out1(df_out1), .df_out2(df_out2), .df_out3(df_out3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] twv(input logic [AW-1:0] e);
        logic [31:0] ee;
        ee = 32'(e);
        return {32'h3F80_0000 + ee * 32'h0001_0203, 32'hBF00_0000 ^ (ee * 32'h0013_5791)};
    endfunction

    // Asymmetric integer stand-in for the dragonfly: any operand swap,
    // twiddle mix-up or scaling change alters the results.
    function automatic logic [63:0] df_fn(input int k, input logic [63:0] a0, a1, a2, a3,
                                          input logic [63:0] tw, input logic [1:0] sc);
        case (k)
            0:       return a0 + a1 + tw;
            1:       return (a0 - a1) ^ {62'd0, sc};
            2:       return a2 + {a3[62:0], 1'b0};
            default: return a2 ^ a3 ^ {tw[31:0], tw[63:32]};
        endcase
    endfunction

    assign df_out0 = df_fn(0, df_in0, df_in1, df_in2, df_in3, df_twiddle, df_scaling);
    assign df_out1 = df_fn(1, df_in0, df_in1, df_in2, df_in3, df_twiddle, df_scaling);
    assign df_out2 = df_fn(2, df_in0, df_in1, df_in2, df_in3, df_twiddle, df_scaling);
    assign df_out3 = df_fn(3, df_in0, df_in1, df_in2, df_in3, df_twiddle, df_scaling);

    // Single-port RAM and twiddle ROM, both 1-cycle synchronous read.
    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
        tw_data   <= twv(tw_addr);
    end

    // Monitor: every write the DUT issues is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wr_seen = wr_seen + 1;
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_bad = n_bad + 1;
                    $display("FAIL unexpected_write: got addr=%0h data=%h, none expected", mem_addr, mem_wdata);
                end else begin
                    mon_w = exp_q.pop_front();
                    if (mem_addr !== mon_w.addr || mem_wdata !== mon_w.data) begin
                        n_bad = n_bad + 1;
                        $display("FAIL write: got addr=%0h data=%h, expected addr=%0h data=%h",
                                 mem_addr, mem_wdata, mon_w.addr, mon_w.data);
                    end
                end
            end
            if (done) begin
                done_seen = done_seen + 1;
                done_cyc  = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},  64'(busy), 64'd0);
        check({name, "_done"},  64'(done), 64'd0);
        check({name, "_we"},    64'(mem_we), 64'd0);
        check({name, "_addr"},  64'({mem_addr, tw_addr}), 64'd0);
        check({name, "_wdata"}, mem_wdata, 64'd0);
        check({name, "_dfin"},  df_in0 | df_in1 | df_in2 | df_in3, 64'd0);
        check({name, "_dftw"},  df_twiddle, 64'd0);
        check({name, "_dfsc"},  64'(df_scaling), 64'd0);
    endtask

    // Load the RAM with a pattern and predict the whole run from the
    // stage/butterfly rules with plain loop arithmetic.
    task automatic prepare(input int pattern, input logic [1:0] sc);
        int L, j, g, base, e;
        logic [63:0] a [4];
        logic [63:0] o [4];
        wr_t w;
        for (int i = 0; i < N; i++) begin
            case (pattern)
                0:       model[i] = {$urandom, $urandom};
                1:       model[i] = 64'(i);
                default: model[i] = (i == 0) ? 64'h3F80_0000_0000_0000 : 64'd0;
            endcase
            @(posedge clk); #1;
            ld_en = 1'b1; ld_addr = AW'(i); ld_data = model[i];
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        for (int s = 0; s < LOG4N; s++) begin
            L = 4 ** s;
            for (int b = 0; b < NB; b++) begin
                j = b % L;
                g = b / L;
                base = g * 4 * L + j;
                e = j * (4 ** (LOG4N - 1 - s));
                for (int k = 0; k < 4; k++) a[k] = model[base + k * L];
                for (int k = 0; k < 4; k++) o[k] = df_fn(k, a[0], a[2], a[1], a[3], twv(AW'(e)), sc);
                for (int k = 0; k < 4; k++) begin
                    model[base + k * L] = o[k];
                    w.addr = AW'(base + k * L);
                    w.data = o[k];
                    exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic run_fft(input int pattern, input logic [1:0] sc, input bit extra);
        int st, d0, t;
        prepare(pattern, sc);
        @(posedge clk); #1;
        scaling = sc; start = 1'b1; st = cyc; d0 = done_seen;
        @(posedge clk); #1;
        start = 1'b0; scaling = ~sc;
        if (extra) begin
            repeat (10) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 check("busy_during_run", 64'(busy), 64'd1);
        check("df_scaling_latched", 64'(df_scaling), 64'(sc));
        t = 0;
        while (done_seen == d0 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        if (done_seen == d0) begin
            n_cmp = n_cmp + 1; n_bad = n_bad + 1;
            $display("FAIL done_timeout: got no done after %0d cycles, required one", t);
            return;
        end
        check("done_latency", 64'(done_cyc - st), 64'(EXP_LAT));
        if (extra) begin
            start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        repeat (20) @(negedge clk);
        #1;
        check("done_count", 64'(done_seen - d0), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        for (int i = 0; i < N; i++) check($sformatf("ram[%0d]", i), ram[i], model[i]);
    endtask

    task automatic reset_mid_run();
        int w0, t;
        prepare(0, 2'b10);
        @(posedge clk); #1;
        scaling = 2'b10; start = 1'b1; w0 = wr_seen;
        @(posedge clk); #1 start = 1'b0;
        t = 0;
        while (wr_seen - w0 < 10 && t < 500) begin
            @(posedge clk); #2;
            t++;
        end
        check("midrun_we_before_reset", 64'(mem_we), 64'd1);
        rst_n = 1'b0;
        #1 check_all_zero("reset_async");
        @(negedge clk);
        check_all_zero("reset_next");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_init");
        #1 rst_n = 1'b1;
        run_fft(1, 2'b01, 1'b1);
        run_fft(0, 2'b10, 1'b0);
        run_fft(2, 2'b00, 1'b0);
        reset_mid_run();
        run_fft(0, 2'b11, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
